// File: rtl/quad_level_pkg.sv
// Shared definitions for the quadrature level block: decode encoding,
// detent threshold and the transition classifier.
package quad_level_pkg;

  typedef enum logic [1:0] {
    QD_NONE    = 2'b00,
    QD_UP      = 2'b01,
    QD_DOWN    = 2'b10,
    QD_ILLEGAL = 2'b11
  } qd_t;

  localparam int DETENT = 4;

  // Gray-code walk {a,b}: 00 -> 10 -> 11 -> 01 -> 00 counts up
  function automatic qd_t qd_decode(input logic [1:0] prev, input logic [1:0] cur);
    qd_t result;
    if (cur == prev) begin
      result = QD_NONE;
    end else if ((cur ^ prev) == 2'b11) begin
      result = QD_ILLEGAL;
    end else begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: result = QD_UP;
        default:                                result = QD_DOWN;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/quad_level_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one
// raw encoder channel.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [CW-1:0] cnt;

  // Any return of s2 to the accepted value restarts the stability count
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out = deb;

endmodule

// File: rtl/quad_level.sv
// Rotary encoder front end: debounced quadrature decode accumulated into
// whole detents, each stepping a saturating or wrapping level register.
module quad_level
  import quad_level_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STEP            = 1,
  parameter int WRAP            = 0,
  parameter int RESET_LEVEL     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam logic [WIDTH:0]        STEP_X    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0]      MAX_LEVEL = '1;
  localparam logic signed [2:0]     SUB_HI    = 3'(DETENT - 1);
  localparam logic signed [2:0]     SUB_LO    = -SUB_HI;

  logic                  deb_a;
  logic                  deb_b;
  logic [1:0]            cur;
  logic [1:0]            prev;
  qd_t                   qd;
  logic signed [2:0]     sub;
  logic signed [2:0]     sub_next;
  logic                  step_up;
  logic                  step_dn;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        diff;
  logic [WIDTH-1:0]      level_next;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .in    (enc_a),
    .out   (deb_a)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .in    (enc_b),
    .out   (deb_b)
  );

  assign cur = {deb_a, deb_b};

  // Quarter steps accumulate in sub; the fourth quarter in one direction is a detent
  always_comb begin
    qd       = qd_decode(prev, cur);
    sub_next = sub;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    case (qd)
      QD_UP: begin
        if (sub == SUB_HI) begin
          sub_next = '0;
          step_up  = 1'b1;
        end else begin
          sub_next = sub + 3'sd1;
        end
      end
      QD_DOWN: begin
        if (sub == SUB_LO) begin
          sub_next = '0;
          step_dn  = 1'b1;
        end else begin
          sub_next = sub - 3'sd1;
        end
      end
      QD_ILLEGAL: sub_next = '0;
      default:    sub_next = sub;
    endcase
  end

  // The extra top bit of sum/diff flags overflow or borrow
  always_comb begin
    sum        = {1'b0, level} + STEP_X;
    diff       = {1'b0, level} - STEP_X;
    level_next = level;
    if (step_up) begin
      if (sum[WIDTH]) level_next = (WRAP != 0) ? sum[WIDTH-1:0] : MAX_LEVEL;
      else            level_next = sum[WIDTH-1:0];
    end else if (step_dn) begin
      if (diff[WIDTH]) level_next = (WRAP != 0) ? diff[WIDTH-1:0] : '0;
      else             level_next = diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 2'b00;
      sub     <= '0;
      level   <= WIDTH'(RESET_LEVEL);
      changed <= 1'b0;
    end else begin
      prev    <= cur;
      sub     <= sub_next;
      level   <= level_next;
      changed <= (level_next != level);
    end
  end

endmodule

// File: doc/quad_level.md
# quad_level

Turns the raw quadrature signals from a rotary encoder into the `level` value consumed by the PWM stage. The block synchronises and debounces the A/B channels, decodes quadrature transitions and accumulates them into whole detents. Each detent steps a registered level value up or down, with either saturating or wrapping arithmetic. One instance sits directly upstream of each PWM channel.

## Interface
- `WIDTH`, 8: width of `level`; must match the downstream PWM `WIDTH`.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before a channel change is accepted; ≥1.
- `STEP`, 1: level increment per detent; 1 ≤ STEP ≤ 2^WIDTH−1.
- `WRAP`, 0: 0 = saturate at 0 / 2^WIDTH−1; 1 = modulo 2^WIDTH.
- `RESET_LEVEL`, 0: value of `level` after reset.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `enc_a`  in  1  raw encoder channel A; asynchronous, may bounce.
- `enc_b`  in  1  raw encoder channel B; asynchronous, may bounce.
- `level`  out  WIDTH  current level, registered; feeds PWM `level`.
- `changed`  out  1  one-cycle pulse on the cycle `level` takes a new value.

## Operation
- **Sync:** each channel passes through a 2-flop synchroniser (`s1`, `s2`).
- **Debounce, per channel:**
  - Keep counter `cnt` and debounced bit `deb`.
  - When `s2 == deb`, clear `cnt`.
  - Otherwise increment `cnt`.
  - When `cnt == DEBOUNCE_CYCLES−1` and a mismatch is present, load `deb <= s2` and clear `cnt`.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1.
- **Decode:**
  - Register `prev = {deb_a, deb_b}` every cycle, then compare `cur = {deb_a, deb_b}` with `prev`.
  - UP sequence: 00→10→11→01→00.
  - DOWN sequence: the reverse.
  - NONE: `cur == prev`.
  - ILLEGAL: both bits differ.
- **Sub-detent accumulator:** signed 3-bit `sub`, range −3..+3.
  - On UP: `sub+1`. If the result would be +4, emit a step-up and set `sub <= 0`.
  - On DOWN: symmetric, emitting a step-down at −4.
  - On ILLEGAL: `sub <= 0`, no step.
  - A reversal simply counts back toward 0.
- **Level update:** computed in WIDTH+1 bits.
  - Step-up: `level+STEP`. If the result exceeds 2^WIDTH−1, use 2^WIDTH−1 when WRAP=0, or the low WIDTH bits when WRAP=1.
  - Step-down: `level−STEP`. If the result is below 0, use 0 when WRAP=0, or modulo 2^WIDTH when WRAP=1.
  - `changed` = 1 exactly when the new value differs from the old. A saturated step gives no pulse.
- **Reset:**
  - `s1`, `s2`, `deb`, `prev` = 0.
  - `cnt` = 0, `sub` = 0.
  - `level` = RESET_LEVEL, `changed` = 0.
  - Reset overrides everything in the same edge, including mid-detent and mid-debounce.
- **Post-reset resting inputs:** at rest the encoder typically reads 11. Both channels then debounce on the same cycle, which decodes as ILLEGAL, so no spurious step occurs.

## Timing
- Let edge k be the first edge at which `s1` samples a new raw value, with the value held stable afterwards:
  - `s2` updates at k+1.
  - `deb` updates at k+DEBOUNCE_CYCLES+1.
  - `sub`/`level`/`changed` update at k+DEBOUNCE_CYCLES+2.
- Any raw reversion before `deb` updates clears `cnt`. Glitches shorter than DEBOUNCE_CYCLES are invisible.
- A and B debouncing on the same cycle is ILLEGAL. Debouncing on different cycles gives two legal single-bit transitions.
- At most one level step per cycle.
- `changed` is high for exactly one cycle per effective step.
- `level` is constant between steps; the downstream PWM may sample it any cycle.

## Structure
- Shared package/header holds:
  - quadrature decode encoding `QD_NONE`, `QD_UP`, `QD_DOWN`, `QD_ILLEGAL` (2 bits);
  - the detent threshold constant 4.
- Sub-module `sync_debounce` (parameter DEBOUNCE_CYCLES; ports clk, reset, in, out) contains the synchroniser, counter and `deb`. It is instantiated once per channel.
- Decode, accumulator and level arithmetic live in `quad_level`.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4, STEP=1, RESET_LEVEL=0 unless stated. Each quadrature state is held for 10 cycles.
- **Reset with idle inputs:** reset 2 cycles with inputs held at 11, then run 50 cycles → `level`=0 and `changed` never asserts.
- **One CW detent:** drive 11→01→00→10→11 → `level` 0→1 with a single `changed` pulse, 6 edges after the edge where `s1` samples the final 11. One CCW detent then returns `level` to 0.
- **Bounce rejection:** 3-cycle low glitch on A, plus A toggling every 2 cycles for 20 cycles then returning → `deb_a` is unchanged and `level` is unchanged.
- **Saturation and wrap:**
  - WRAP=0, RESET_LEVEL=255: CW detent → 255 with no `changed`; 256 CCW detents → 0; a further CCW → 0 with no pulse.
  - WRAP=1: 255 + CW → 0; STEP=100 at 200 + CW → 44.
- **Reversal and illegal transitions:**
  - Two CW quarters then two CCW quarters → no step, `sub` back to 0.
  - Forced simultaneous A/B flip (00→11) → `sub` cleared, no step.
- **Reset mid-operation:** after 3 CW quarters at `level`=5, assert reset for 1 cycle → `level`=0, `sub`=0, `changed`=0. The next single quarter produces no step.
